// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory (synchronous read, one-cycle latency)
// between the processor load/store path (CPU port) and the debug/loader
// port (DBG port). The CPU has priority. The CPU is stalled on any cycle
// where it requests but is not granted.
//
// Optional feature macro: DMEM_ARB_STARVE_EN
//   defined   : a DBG request denied STARVE_MAX cycles in a row is forced a
//               grant over the CPU on the next cycle.
//   undefined : strict CPU priority. No starvation counter is built.
//
// Parameters
//   ADDR_W      word address width
//   DATA_W      data width
//   STARVE_MAX  consecutive denied DBG cycles before a forced grant (1..15)
//
// Ports
//   clk                       clock, rising edge
//   rst                       synchronous reset, active low (0 = reset)
//   cpu_req/we/addr/wdata     CPU request, held until cpu_gnt
//   cpu_gnt                   combinational grant for this cycle
//   cpu_stall                 cpu_req & ~cpu_gnt
//   cpu_rvalid/rdata          load return, one cycle after a load grant
//   dbg_*                     same as the CPU port, without a stall output
//   mem_en/we/addr/wdata      memory strobe and muxed request, 0 when idle
//   mem_rdata                 memory read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The starvation counter is 4 bits wide, so the limit must fit in 1..15.
  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in the range 1..15");
  end

  // Owner of the load whose data the memory returns this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DBG  = 2'd2
  } rd_state_e;

  rd_state_e rd_state_q, rd_state_d;

  // Set when DBG has waited long enough to take the memory from the CPU.
  logic force_dbg;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign force_dbg = dbg_req && (starve_cnt_q == STARVE_LIMIT);

  // Counts consecutive denied DBG cycles. A grant or a dropped request
  // restarts the count, and it saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg_req || dbg_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_dbg = 1'b0;
`endif

  // Grants are gated by reset so that no memory access can start while the
  // block is being reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      if (force_dbg) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // The memory request is driven only by the winner. Otherwise it is all
  // zero, so the memory never sees stale addresses or data.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Read-return FSM, state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q <= RD_NONE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  // Read-return FSM, next state. Ownership lasts exactly one cycle. Every
  // cycle the state is rebuilt from this cycle's grant alone.
  always_comb begin
    rd_state_d = RD_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_state_d = RD_CPU;
    end else if (dbg_gnt && !dbg_we) begin
      rd_state_d = RD_DBG;
    end
  end

  // Read-return FSM, outputs. Return data is also gated by rst. This keeps a
  // load granted just before reset from surfacing while reset is held.
  always_comb begin
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    dbg_rvalid = 1'b0;
    dbg_rdata  = '0;
    if (rst) begin
      case (rd_state_q)
        RD_CPU: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = mem_rdata;
        end
        RD_DBG: begin
          dbg_rvalid = 1'b1;
          dbg_rdata  = mem_rdata;
        end
        default: begin
          cpu_rvalid = 1'b0;
          dbg_rvalid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. A behavioural 1024 x 32 synchronous memory sits
// behind the arbiter. Expected grants, memory requests and load returns come
// from a reference model in this file. That model keeps its own copy of the
// memory contents, built from the stores the arbiter should have performed.
// Build with or without DMEM_ARB_STARVE_EN. The expectations follow the
// macro.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Physical memory behind the arbiter, and the contents the model expects.
  logic [DATA_W-1:0] mem_array [0:1023];
  logic [DATA_W-1:0] ref_mem   [0:15];

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr];
    end
  end

  // Inputs change just after the rising edge. Outputs are sampled on the
  // falling edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_cpu(1'b1, 1'b0, '0, '0);
    set_dbg(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      if ({cpu_gnt, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid} !== 5'b00000) begin
        $display("[TB] FAIL reset_ctrl cycle %0d: got %b expected 00000", i,
                 {cpu_gnt, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid});
      end else pass_cnt++;
      total_cnt++;
      if ({cpu_stall, cpu_rdata, dbg_rdata} !== {1'b1, 64'h0}) begin
        $display("[TB] FAIL reset_stall_rdata cycle %0d: stall=%b cpu_rdata=%h dbg_rdata=%h expected 1/0/0",
                 i, cpu_stall, cpu_rdata, dbg_rdata);
      end else pass_cnt++;
      total_cnt++;
    end
    next_cycle();
    rst = 1'b1;
    sample();
    if ({cpu_gnt, dbg_gnt, cpu_stall, mem_en} !== 4'b1001) begin
      $display("[TB] FAIL reset_release: gnt/dgnt/stall/en got %b expected 1001",
               {cpu_gnt, dbg_gnt, cpu_stall, mem_en});
    end else pass_cnt++;
    total_cnt++;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    sample();
    if ({cpu_rvalid, dbg_rvalid} !== 2'b10) begin
      $display("[TB] FAIL reset_first_load_rvalid: got %b expected 10", {cpu_rvalid, dbg_rvalid});
    end else pass_cnt++;
    total_cnt++;
  endtask

  // Uses DBG stores to fill addresses 0..15 with random data.
  task automatic test_preload;
    logic [DATA_W-1:0] d;
    for (int a = 0; a < 16; a++) begin
      next_cycle();
      d = $urandom;
      set_dbg(1'b1, 1'b1, ADDR_W'(a), d);
      sample();
      if ({cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata, dbg_rvalid} !==
          {4'b0111, ADDR_W'(a), d, 1'b0}) begin
        $display("[TB] FAIL dbg_store addr %0d: gnt=%b/%b en=%b we=%b addr=%0d wdata=%h rv=%b expected 0/1 1 1 %0d %h 0",
                 a, cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata, dbg_rvalid, a, d);
      end else pass_cnt++;
      total_cnt++;
      ref_mem[a] = d;
    end
    next_cycle();
    set_dbg(1'b0, 1'b0, '0, '0);
    sample();
  endtask

  task automatic test_store_load;
    next_cycle();
    set_cpu(1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    sample();
    if ({cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd5, 32'hDEADBEEF}) begin
      $display("[TB] FAIL cpu_store: gnt/en/we=%b addr=%0d wdata=%h expected 111 5 deadbeef",
               {cpu_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end else pass_cnt++;
    total_cnt++;
    ref_mem[5] = 32'hDEADBEEF;
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'd5, '0);
    sample();
    if ({cpu_gnt, mem_we, cpu_rvalid, dbg_rvalid} !== 4'b1000) begin
      $display("[TB] FAIL cpu_load_issue: gnt/we/rv/drv got %b expected 1000",
               {cpu_gnt, mem_we, cpu_rvalid, dbg_rvalid});
    end else pass_cnt++;
    total_cnt++;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    sample();
    if ({cpu_rvalid, cpu_rdata, dbg_rvalid} !== {1'b1, ref_mem[5], 1'b0}) begin
      $display("[TB] FAIL store_then_load: rv=%b rdata=%h drv=%b expected 1 %h 0",
               cpu_rvalid, cpu_rdata, dbg_rvalid, ref_mem[5]);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_collision;
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'd3, '0);
    set_dbg(1'b1, 1'b0, 10'd7, '0);
    sample();
    if ({cpu_gnt, dbg_gnt, cpu_stall, mem_addr} !== {3'b100, 10'd3}) begin
      $display("[TB] FAIL collision_first: gnt/dgnt/stall=%b addr=%0d expected 100 3",
               {cpu_gnt, dbg_gnt, cpu_stall}, mem_addr);
    end else pass_cnt++;
    total_cnt++;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    sample();
    if ({cpu_gnt, dbg_gnt, mem_addr, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !==
        {2'b01, 10'd7, 1'b1, ref_mem[3], 1'b0, 32'h0}) begin
      $display("[TB] FAIL collision_second: gnt=%b/%b addr=%0d crv=%b crd=%h drv=%b drd=%h expected 0/1 7 1 %h 0 0",
               cpu_gnt, dbg_gnt, mem_addr, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata, ref_mem[3]);
    end else pass_cnt++;
    total_cnt++;
    next_cycle();
    set_dbg(1'b0, 1'b0, '0, '0);
    sample();
    if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {1'b0, 32'h0, 1'b1, ref_mem[7]}) begin
      $display("[TB] FAIL collision_dbg_return: crv=%b crd=%h drv=%b drd=%h expected 0 0 1 %h",
               cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata, ref_mem[7]);
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [1:0] owner [0:3];
    logic [3:0] addr  [0:3];
    owner[0] = 2'd1; owner[1] = 2'd2; owner[2] = 2'd1; owner[3] = 2'd0;
    addr[0]  = 4'd1; addr[1]  = 4'd2; addr[2]  = 4'd3; addr[3]  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      set_cpu(owner[i] == 2'd1, 1'b0, ADDR_W'(addr[i]), '0);
      set_dbg(owner[i] == 2'd2, 1'b0, ADDR_W'(addr[i]), '0);
      sample();
      if (i > 0) begin
        if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !==
            {owner[i-1] == 2'd1, (owner[i-1] == 2'd1) ? ref_mem[addr[i-1]] : 32'h0,
             owner[i-1] == 2'd2, (owner[i-1] == 2'd2) ? ref_mem[addr[i-1]] : 32'h0}) begin
          $display("[TB] FAIL back_to_back step %0d: crv=%b crd=%h drv=%b drd=%h expected owner %0d data %h",
                   i, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata, owner[i-1], ref_mem[addr[i-1]]);
        end else pass_cnt++;
        total_cnt++;
      end
    end
  endtask

  task automatic test_reset_abort;
    next_cycle();
    set_cpu(1'b1, 1'b0, 10'd9, '0);
    sample();
    if (cpu_gnt !== 1'b1) begin
      $display("[TB] FAIL abort_grant: got %b expected 1", cpu_gnt);
    end else pass_cnt++;
    total_cnt++;
    next_cycle();
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, '0, '0);
    sample();
    if ({cpu_rvalid, cpu_rdata} !== 33'h0) begin
      $display("[TB] FAIL abort_in_reset: rv=%b rdata=%h expected 0 0", cpu_rvalid, cpu_rdata);
    end else pass_cnt++;
    total_cnt++;
    next_cycle();
    rst = 1'b1;
    sample();
    if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
      $display("[TB] FAIL abort_after_reset: rv=%b expected 00", {cpu_rvalid, dbg_rvalid});
    end else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_starvation;
    int waited = 0;
    int grants = 0;
    bit exp_dbg;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      set_cpu(1'b1, 1'b0, 10'd4, '0);
      set_dbg(1'b1, 1'b0, 10'd6, '0);
      sample();
      exp_dbg = STARVE_EN && (waited == STARVE_MAX);
      if ({cpu_gnt, dbg_gnt, cpu_stall} !== {!exp_dbg, exp_dbg, exp_dbg}) begin
        $display("[TB] FAIL starvation cycle %0d: gnt/dgnt/stall got %b expected %b",
                 i, {cpu_gnt, dbg_gnt, cpu_stall}, {!exp_dbg, exp_dbg, exp_dbg});
      end else pass_cnt++;
      total_cnt++;
      if (dbg_gnt === 1'b1) grants++;
      waited = exp_dbg ? 0 : ((waited < STARVE_MAX) ? waited + 1 : waited);
    end
    if (grants !== (STARVE_EN ? 10 : 0)) begin
      $display("[TB] FAIL starvation_grant_count: got %0d expected %0d", grants, STARVE_EN ? 10 : 0);
    end else pass_cnt++;
    total_cnt++;
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    sample();
  endtask

  // Random traffic from both ports. Each requester holds a request until it
  // is granted, or occasionally abandons it.
  task automatic test_random;
    bit c_act = 0, d_act = 0, c_we = 0, d_we = 0;
    logic [3:0]        c_a = '0, d_a = '0;
    logic [DATA_W-1:0] c_d = '0, d_d = '0;
    int  waited = 0;
    bit  force_d, e_cg, e_dg;
    bit  e_crv = 0, e_drv = 0;
    logic [DATA_W-1:0] e_crd = '0, e_drd = '0;
    logic [DATA_W-1:0] e_wd;
    logic [3:0]        e_a;
    bit                e_we;
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      if (!c_act) begin
        c_act = ($urandom_range(0, 99) < 60);
        c_we = $urandom_range(0, 1) == 1; c_a = 4'($urandom_range(0, 15)); c_d = $urandom;
      end else if ($urandom_range(0, 19) == 0) c_act = 0;
      if (!d_act) begin
        d_act = ($urandom_range(0, 99) < 60);
        d_we = $urandom_range(0, 1) == 1; d_a = 4'($urandom_range(0, 15)); d_d = $urandom;
      end else if ($urandom_range(0, 19) == 0) d_act = 0;
      set_cpu(c_act, c_we, ADDR_W'(c_a), c_d);
      set_dbg(d_act, d_we, ADDR_W'(d_a), d_d);

      force_d = STARVE_EN && d_act && (waited == STARVE_MAX);
      e_cg = c_act && !force_d;
      e_dg = d_act && (force_d || !c_act);
      e_we = e_cg ? c_we : (e_dg ? d_we : 1'b0);
      e_a  = e_cg ? c_a  : (e_dg ? d_a  : 4'd0);
      e_wd = e_cg ? c_d  : (e_dg ? d_d  : 32'h0);
      sample();

      if ({cpu_gnt, dbg_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata} !==
          {e_cg, e_dg, c_act && !e_cg, e_cg || e_dg, e_we, ADDR_W'(e_a), e_wd}) begin
        $display("[TB] FAIL random_req cycle %0d: gnt=%b/%b stall=%b en=%b we=%b addr=%0d wd=%h expected %b/%b %b %b %b %0d %h",
                 i, cpu_gnt, dbg_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata,
                 e_cg, e_dg, c_act && !e_cg, e_cg || e_dg, e_we, e_a, e_wd);
      end else pass_cnt++;
      total_cnt++;
      if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !== {e_crv, e_crd, e_drv, e_drd}) begin
        $display("[TB] FAIL random_ret cycle %0d: crv=%b crd=%h drv=%b drd=%h expected %b %h %b %h",
                 i, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata, e_crv, e_crd, e_drv, e_drd);
      end else pass_cnt++;
      total_cnt++;

      e_crv = e_cg && !c_we;
      e_crd = e_crv ? ref_mem[c_a] : 32'h0;
      e_drv = e_dg && !d_we;
      e_drd = e_drv ? ref_mem[d_a] : 32'h0;
      if ((e_cg || e_dg) && e_we) ref_mem[e_a] = e_wd;
      waited = (!d_act || e_dg) ? 0 : ((waited < STARVE_MAX) ? waited + 1 : waited);
      if (e_cg) c_act = 0;
      if (e_dg) d_act = 0;
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_store_load();
    test_collision();
    test_back_to_back();
    test_reset_abort();
    test_starvation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory (1024 x 32, synchronous read, 1-cycle latency). It shares the memory between the processor load/store path (CPU port) and a debug/loader port (DBG port) used by benches and a future boot loader to preload or inspect data memory. It sits between `mips_processor`'s load/store datapath and `data_mem`. The CPU is stalled on any cycle it loses arbitration.

## Interface
- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive denied DBG cycles before DBG is forced a grant (range 1..15)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset)
- `cpu_req`  in  1  CPU access request, held until granted
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_W  word address
- `cpu_wdata`  in  DATA_W  store data
- `cpu_gnt`  out  1  combinational grant this cycle
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid`  out  1  load data valid (cycle after grant)
- `cpu_rdata`  out  DATA_W  load data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`  same semantics as the CPU port
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en & ~mem_we`

## Operation
- Grant is combinational from the current requests and registered state. At most one grant per cycle.
- Default priority: CPU beats DBG. DBG is granted when `dbg_req & ~cpu_req`, or when forced (see Configuration).
- The granted port's `we`, `addr` and `wdata` are muxed to `mem_*`. `mem_en = cpu_gnt | dbg_gnt`. All `mem_*` outputs are 0 when there is no grant.
- Read-return FSM, registered owner of the in-flight load:
  - States: `RD_NONE`, `RD_CPU`, `RD_DBG`.
  - Next state is `RD_CPU` on a granted CPU load, `RD_DBG` on a granted DBG load, otherwise `RD_NONE`. Back-to-back loads re-enter the same or the other state each cycle.
  - In `RD_CPU`: `cpu_rvalid = 1` and `cpu_rdata = mem_rdata`. `RD_DBG` behaves the same way for the DBG port.
  - Non-owner `rdata` is 0. The state is never held past one cycle.
- Stores produce no `rvalid`.
- Starvation counter `starve_cnt` (4 bits):
  - Increments each cycle `dbg_req & ~dbg_gnt`.
  - Clears on `dbg_gnt` or on `~dbg_req`.
  - Saturates at `STARVE_MAX`.
- Requester rule: a requester must keep `req`/`we`/`addr`/`wdata` stable until it sees `gnt`. Dropping `req` before `gnt` is legal and abandons the request with no side effect.

## Timing
- Reset (`rst == 0` at an edge):
  - FSM goes to `RD_NONE`; `starve_cnt = 0`.
  - During and after reset, `cpu_rvalid`, `dbg_rvalid`, `cpu_rdata` and `dbg_rdata` are 0.
  - While `rst == 0`, both grants are forced to 0 and `mem_en = 0`, so `cpu_stall = cpu_req`.
  - A load granted in the cycle before reset asserts returns no `rvalid`.
- Write: the memory updates on the grant-cycle edge; a load of the same address granted in the next cycle returns the new data.
- Read: `rvalid`/`rdata` appear exactly 1 cycle after the grant cycle.
- Sustained throughput: one access per cycle.
- Simultaneous requests in the same cycle: the CPU wins unless the DBG grant is forced. In that cycle `cpu_stall = 1`.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - When `starve_cnt == STARVE_MAX` and `dbg_req`, DBG is granted even if `cpu_req`. The CPU stalls for that cycle, then the counter clears.
  - The worst-case DBG wait is therefore `STARVE_MAX` cycles.
- Not defined:
  - Strict CPU priority; `starve_cnt` is not implemented.
  - DBG waits indefinitely under continuous `cpu_req`.

## Test plan
- Reset and idle: hold `rst = 0` for 3 cycles with both `req = 1` -> `gnt = 0`, `mem_en = 0`, `rvalid = 0`, `cpu_stall = 1`. Release reset -> `cpu_gnt = 1` in the first cycle.
- Store then load, with `mem_rdata` modelled by the bench as a 1024 x 32 memory:
  - CPU stores `0xDEADBEEF` to address 5, then loads address 5.
  - Next cycle -> `cpu_rvalid = 1`, `cpu_rdata = 0xDEADBEEF`, `dbg_rvalid = 0`.
- Collision: `cpu_req` (load address 3) and `dbg_req` (load address 7) in the same cycle:
  - CPU granted first; DBG granted the following cycle once `cpu_req` drops.
  - Each `rvalid` goes to the correct port, one cycle after its own grant.
- Starvation, `DMEM_ARB_STARVE_EN` defined, `STARVE_MAX = 4`, `cpu_req` held high:
  - `dbg_gnt` on the 5th cycle of `dbg_req`; `cpu_stall = 1` in exactly that cycle.
  - Repeats every 5 cycles.
- Starvation, macro undefined: same stimulus for 50 cycles -> `dbg_gnt` never asserts.
- Back-to-back alternating loads CPU, DBG, CPU to addresses 1, 2, 3 with only the active requester asserting:
  - FSM sequence `RD_CPU`, `RD_DBG`, `RD_CPU`.
  - `rdata` matches memory contents on each port, with no cross-talk.
